// File: rtl/bnw_scan_ctrl.sv
// ---------------------------------------------------------------------------
// bnw_scan_ctrl
//
// Time-multiplexed scan controller for a four-digit, common-anode seven
// segment display. Each digit owns one slot of SCAN_DIV clk cycles. The first
// BLANK_CYC cycles of a slot are blanked (all digit enables off) to hide
// ghosting while the anode switches. The remaining cycles drive the digit.
//
// Display data is double-buffered. A new frame of digits is accepted only on
// the last cycle of a frame, so the visible data never changes in the middle
// of a frame.
//
// Parameters
//   SCAN_DIV   clk cycles per digit slot (2..65535)
//   BLANK_CYC  blanking cycles at the start of each slot (0..SCAN_DIV-1)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   upd_valid   new display data is offered
//   upd_digits  four hex digits, [3:0] = digit 0 (rightmost)
//   upd_dp      decimal-point enables, bit n = digit n
//   lz_en       leading-zero suppression enable
//   upd_ready   high only in the frame-boundary acceptance cycle
//   ssd_ctl     active-low digit enables (registered)
//   ssd_seg     active-low segments {dp,g,f,e,d,c,b,a} (registered)
//   frame_done  one-cycle pulse on the last cycle of each frame
// ---------------------------------------------------------------------------
module bnw_scan_ctrl #(
  parameter int SCAN_DIV  = 32768,
  parameter int BLANK_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  input  logic [15:0] upd_digits,
  input  logic [3:0]  upd_dp,
  input  logic        lz_en,
  output logic        upd_ready,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  ssd_seg,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // With no blanking cycles the slot is driven from its very first cycle.
  localparam state_t ST_INIT = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  // Hex digit to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // True when a slot position falls inside the blanking window. Compared as
  // int so a zero-length window needs no special case.
  function automatic logic in_blank(input logic [CNT_W-1:0] c);
    return (int'(c) < BLANK_CYC);
  endfunction

  // Slot position and held frame data.
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [1:0]       idx;
  state_t           state;
  logic [15:0]      held_digits;
  logic [3:0]       held_dp;

  logic             slot_end;
  logic             frame_end;
  logic [3:0]       digit_cur;
  logic             dp_cur;
  logic             lz_blank;
  logic [3:0]       ctl_d;
  logic [7:0]       seg_d;

  // Output register stage, one cycle behind cnt/idx/state.
  logic [3:0]       ctl_p1;
  logic [7:0]       seg_p1;

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == 2'd3);
    cnt_nxt   = slot_end ? '0 : cnt + CNT_W'(1);
  end

  // Acceptance is only offered in the final cycle of a frame, and never
  // during reset so a coinciding handshake cannot leak through.
  assign upd_ready  = frame_end & ~rst;
  assign frame_done = frame_end & ~rst;

  // ---- stage 0 -> 1: decode current slot into next output value ----------
  always_comb begin
    digit_cur = held_digits[{idx, 2'b00} +: 4];
    dp_cur    = held_dp[idx];

    // A digit is a leading zero only if it and every digit to its left are
    // zero. Digit 0 always shows so a zero value still reads "0".
    lz_blank = 1'b0;
    case (idx)
      2'd3:    lz_blank = (held_digits[15:12] == 4'h0);
      2'd2:    lz_blank = (held_digits[15:8]  == 8'h00);
      2'd1:    lz_blank = (held_digits[15:4]  == 12'h000);
      default: lz_blank = 1'b0;
    endcase
    lz_blank = lz_blank && lz_en;

    ctl_d = 4'b1111;
    seg_d = 8'hFF;
    if (state == ST_DRIVE) begin
      ctl_d = ~(4'b0001 << idx);
      // The decimal point is independent of suppression.
      seg_d = {~dp_cur, lz_blank ? 7'h7F : hex7(digit_cur)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= 2'd0;
      state       <= ST_INIT;
      held_digits <= 16'h0000;
      held_dp     <= 4'h0;
      ctl_p1      <= 4'b1111;
      seg_p1      <= 8'hFF;
    end else begin
      cnt <= cnt_nxt;
      if (slot_end) begin
        idx <= idx + 2'd1;
      end
      // State tracks the slot position it will sit at after this edge.
      state <= in_blank(cnt_nxt) ? ST_BLANK : ST_DRIVE;

      ctl_p1 <= ctl_d;
      seg_p1 <= seg_d;

      // Loading on the frame boundary makes new data first visible in the
      // digit-0 slot of the next frame.
      if (upd_valid && upd_ready) begin
        held_digits <= upd_digits;
        held_dp     <= upd_dp;
      end
    end
  end

  assign ssd_ctl = ctl_p1;
  assign ssd_seg = seg_p1;

endmodule

// File: tb/tb_bnw_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bnw_scan_ctrl
//
// Bench for bnw_scan_ctrl with SCAN_DIV=8. Two instances share stimulus: one
// with BLANK_CYC=2 and one with BLANK_CYC=0. A cycle model pushes the
// expected registered outputs into a scoreboard queue before each edge; they
// are popped and compared just after the edge. Directed checks with literal
// values cover the worked examples.
// ---------------------------------------------------------------------------
module tb_bnw_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_valid;
  logic [15:0] upd_digits;
  logic [3:0]  upd_dp;
  logic        lz_en;

  logic        upd_ready,  frame_done;
  logic [3:0]  ssd_ctl;
  logic [7:0]  ssd_seg;
  logic        upd_ready0, frame_done0;
  logic [3:0]  ssd_ctl0;
  logic [7:0]  ssd_seg0;

  bnw_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_digits(upd_digits),
    .upd_dp(upd_dp), .lz_en(lz_en), .upd_ready(upd_ready),
    .ssd_ctl(ssd_ctl), .ssd_seg(ssd_seg), .frame_done(frame_done)
  );

  bnw_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_digits(upd_digits),
    .upd_dp(upd_dp), .lz_en(lz_en), .upd_ready(upd_ready0),
    .ssd_ctl(ssd_ctl0), .ssd_seg(ssd_seg0), .frame_done(frame_done0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: m_* is the slot before the next edge, p_* is the slot the
  // outputs currently on the pins were derived from (-1 = reset value).
  int          m_cnt = 0, m_idx = 0;
  int          p_cnt = -1, p_idx = -1;
  logic [15:0] m_dig = 16'h0;
  logic [3:0]  m_dp  = 4'h0;
  logic [23:0] sb[$];
  logic        last_fd, last_rdy;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_hex(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d];
  endfunction

  function automatic logic [11:0] ref_out(input int bc, input int cnt, input int idx,
                                          input logic [15:0] dig, input logic [3:0] dp,
                                          input logic lz);
    logic [3:0] ctl;
    logic       blank;
    if (cnt < bc) return {4'hF, 8'hFF};
    ctl = 4'hF;
    ctl[idx] = 1'b0;
    blank = 1'b0;
    if (lz && idx > 0) begin
      blank = 1'b1;
      for (int j = idx; j < 4; j++) if (dig[j*4 +: 4] != 4'h0) blank = 1'b0;
    end
    return {ctl, ~dp[idx], blank ? 7'h7F : ref_hex(dig[idx*4 +: 4])};
  endfunction

  task automatic step();
    logic        er;
    logic [23:0] e;
    @(negedge clk);
    er = !rst && m_idx == 3 && m_cnt == SD - 1;
    last_fd  = frame_done;
    last_rdy = upd_ready;
    chk("upd_ready",   {23'd0, upd_ready},   {23'd0, er});
    chk("frame_done",  {23'd0, frame_done},  {23'd0, er});
    chk("upd_ready0",  {23'd0, upd_ready0},  {23'd0, er});
    chk("frame_done0", {23'd0, frame_done0}, {23'd0, er});
    if (rst) e = {4'hF, 8'hFF, 4'hF, 8'hFF};
    else     e = {ref_out(BC, m_cnt, m_idx, m_dig, m_dp, lz_en),
                  ref_out(0,  m_cnt, m_idx, m_dig, m_dp, lz_en)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_dig = 16'h0; m_dp = 4'h0; p_cnt = -1; p_idx = -1;
    end else begin
      if (upd_valid && er) begin m_dig = upd_digits; m_dp = upd_dp; end
      p_cnt = m_cnt; p_idx = m_idx;
      if (m_cnt == SD - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % 4; end
      else m_cnt++;
    end
    chk("scan_out", {ssd_ctl, ssd_seg, ssd_ctl0, ssd_seg0}, sb.pop_front());
  endtask

  // Advance until the outputs reflect slot (i,c) (pre=0) or until the model
  // sits at (i,c) before the next edge (pre=1).
  task automatic goto(input int i, input int c, input bit pre);
    int   n;
    logic hit;
    n = 0;
    hit = pre ? (m_idx == i && m_cnt == c) : (p_idx == i && p_cnt == c);
    while (!hit && n < 100) begin
      step();
      n++;
      hit = pre ? (m_idx == i && m_cnt == c) : (p_idx == i && p_cnt == c);
    end
    chk("goto_reached", {23'd0, hit}, 24'd1);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    upd_valid = 1'b1; upd_digits = d; upd_dp = p;
    goto(3, SD - 1, 1'b1);
    step();
    upd_valid = 1'b0;
  endtask

  initial begin
    int n1110, nf, nc0, nfd, fd_at, nf0, nrdy;
    rst = 1'b1; upd_valid = 1'b0; upd_digits = 16'h0; upd_dp = 4'h0; lz_en = 1'b0;
    repeat (3) step();
    chk("rst_ctl", {20'd0, ssd_ctl}, 24'h00000F);
    chk("rst_seg", {16'd0, ssd_seg}, 24'h0000FF);

    // Plain scan of one frame after reset release.
    rst = 1'b0;
    n1110 = 0; nf = 0; nc0 = 0; nfd = 0; fd_at = -1;
    for (int k = 0; k < 32; k++) begin
      step();
      if (ssd_ctl == 4'b1110) n1110++;
      if (ssd_ctl == 4'b1111) nf++;
      if (ssd_ctl != 4'b1111 && ssd_seg == 8'hC0) nc0++;
      if (last_fd) begin nfd++; fd_at = k; end
    end
    chk("cnt_1110", 24'(n1110), 24'd6);
    chk("cnt_blank", 24'(nf), 24'd8);
    chk("cnt_c0", 24'(nc0), 24'd24);
    chk("fd_count", 24'(nfd), 24'd1);
    chk("fd_cycle", 24'(fd_at), 24'd31);

    // Handshake offered early in a frame: nothing changes until the boundary.
    upd_valid = 1'b1; upd_digits = 16'h12A8; upd_dp = 4'b0010;
    repeat (3) step();
    chk("no_early_load", {16'd0, ssd_seg}, 24'h0000C0);
    goto(3, SD - 1, 1'b1);
    step();
    upd_valid = 1'b0;
    goto(0, 4, 1'b0); chk("d0_seg", {16'd0, ssd_seg}, 24'h000080);
    goto(1, 4, 1'b0); chk("d1_seg", {16'd0, ssd_seg}, 24'h000008);
    chk("d1_ctl", {20'd0, ssd_ctl}, 24'h00000D);
    goto(2, 4, 1'b0); chk("d2_seg", {16'd0, ssd_seg}, 24'h0000A4);
    goto(3, 4, 1'b0); chk("d3_seg", {16'd0, ssd_seg}, 24'h0000F9);

    // Leading-zero suppression.
    lz_en = 1'b1;
    load(16'h0070, 4'h0);
    goto(0, 4, 1'b0); chk("lz_d0", {16'd0, ssd_seg}, 24'h0000C0);
    goto(1, 4, 1'b0); chk("lz_d1", {16'd0, ssd_seg}, 24'h0000F8);
    goto(2, 4, 1'b0); chk("lz_d2", {ssd_ctl, ssd_seg}, 24'h000BFF);
    goto(3, 4, 1'b0); chk("lz_d3", {ssd_ctl, ssd_seg}, 24'h0007FF);
    lz_en = 1'b0;
    goto(2, 4, 1'b0); chk("nolz_d2", {16'd0, ssd_seg}, 24'h0000C0);
    goto(3, 4, 1'b0); chk("nolz_d3", {16'd0, ssd_seg}, 24'h0000C0);

    // Reset in the middle of the digit-2 drive phase.
    load(16'hFFFF, 4'h0);
    goto(2, 4, 1'b0); chk("f_d2", {16'd0, ssd_seg}, 24'h00008E);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out", {ssd_ctl, ssd_seg}, 24'h000FFF);
    repeat (3) step();
    chk("restart_d0", {ssd_ctl, ssd_seg}, 24'h000EC0);
    goto(3, 4, 1'b0); chk("zeroed_d3", {16'd0, ssd_seg}, 24'h0000C0);

    // Handshake coinciding with reset is dropped.
    upd_valid = 1'b1; upd_digits = 16'h5555; upd_dp = 4'hF;
    goto(3, SD - 1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0; upd_valid = 1'b0;
    goto(0, 4, 1'b0); chk("rst_wins", {16'd0, ssd_seg}, 24'h0000C0);

    // Valid held high: one load per frame, data may change while waiting.
    upd_valid = 1'b1; upd_digits = 16'h1111; upd_dp = 4'h0;
    nf0 = 0; nrdy = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 40) upd_digits = 16'h3333;
      step();
      if (ssd_ctl0 == 4'b1111) nf0++;
      if (last_rdy) nrdy++;
    end
    upd_valid = 1'b0;
    chk("bc0_never_blank", 24'(nf0), 24'd0);
    chk("loads_per_2frames", 24'(nrdy), 24'd2);
    goto(1, 4, 1'b0); chk("last_load", {16'd0, ssd_seg}, 24'h0000B0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bnw_scan_ctrl.md
BNW_SCAN_CTRL -- requirements
Module: bnw_scan_ctrl

Interface
- REQ-001: Parameter SCAN_DIV, default 32768, SHALL set the number of clk cycles per digit slot; legal range 2..65535.
- REQ-002: Parameter BLANK_CYC, default 1024, SHALL set the number of blanking cycles at the start of each slot; legal range 0..SCAN_DIV-1.
- REQ-003: clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  SHALL be the synchronous, active-high reset.
- REQ-005: upd_valid  input  1  SHALL mean new display data is offered.
- REQ-006: upd_digits  input  16  SHALL carry four hex digits: [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- REQ-007: upd_dp  input  4  SHALL carry the decimal-point enables, where bit n belongs to digit n.
- REQ-008: lz_en  input  1  SHALL enable leading-zero suppression.
- REQ-009: upd_ready  output  1  SHALL mark the frame-boundary acceptance cycle.
- REQ-010: ssd_ctl  output  4  SHALL be the active-low digit enables.
- REQ-011: ssd_seg  output  8  SHALL be the active-low segments {dp,g,f,e,d,c,b,a}.
- REQ-012: frame_done  output  1  SHALL be a one-cycle pulse at the end of each frame.

Function
- REQ-013: A slot counter cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; a 2-bit digit index idx SHALL increment (3->0 wrap) on each wrap.
- REQ-014: The FSM SHALL have two states. BLANK holds while cnt < BLANK_CYC. DRIVE holds while cnt >= BLANK_CYC. With BLANK_CYC=0, BLANK SHALL never be entered.
- REQ-015: In BLANK, the registered outputs SHALL be ssd_ctl=4'b1111 and ssd_seg=8'hFF.
- REQ-016: In DRIVE, ssd_ctl SHALL drive bit idx low and all other bits high, and ssd_seg SHALL carry the decoded held digit idx.
- REQ-017: ssd_ctl and ssd_seg SHALL be registered, lagging cnt/idx/state by exactly one cycle.
- REQ-018: The decoder SHALL map hex 0-F to the standard active-low patterns, for example 0->7'h40, 8->7'h00, F->7'h0E on {g..a}. ssd_seg[7] SHALL equal ~held_dp[idx].
- REQ-019: Leading-zero suppression, when lz_en=1, SHALL blank segments g..a of:
  - digit 3 if digit 3==0;
  - digit 2 if digits 3 and 2 are 0;
  - digit 1 if digits 3..1 are 0;
  - never digit 0.
- REQ-020: The dp bit SHALL still follow held_dp on a digit blanked by leading-zero suppression; leading-zero suppression never changes ssd_ctl.
- REQ-021: Evaluation of lz_en SHALL be combinational at the output register input, so a change takes effect on the next cycle.
- REQ-022: upd_ready SHALL be 1 (combinationally) only in the cycle where idx==3 and cnt==SCAN_DIV-1, and SHALL be 0 in every other cycle.
- REQ-023: frame_done SHALL be 1 in that same cycle.
- REQ-024: When upd_valid && upd_ready, held_digits/held_dp SHALL load upd_digits/upd_dp at that edge, so the new data first appears in the digit-0 slot of the next frame.
- REQ-025: upd_valid without upd_ready SHALL have no effect.
- REQ-026: The sender SHALL be allowed to hold upd_valid across cycles; data SHALL NOT be consumed and upd_valid SHALL NOT be required to stay asserted.
- REQ-027: Held data SHALL never change mid-frame, so there is no tearing.
- REQ-028: All counters SHALL be unsigned, with cnt width ceil(log2(SCAN_DIV)); no overflow beyond the wrap at SCAN_DIV-1.

Reset
- REQ-029: When rst=1 at a clock edge, the following SHALL take effect at that edge: cnt=0, idx=0, state=BLANK (DRIVE if BLANK_CYC=0), held_digits=16'h0000, held_dp=4'h0, ssd_ctl=4'b1111, ssd_seg=8'hFF.
- REQ-030: upd_ready and frame_done SHALL be 0 while rst=1, regardless of cnt/idx.
- REQ-031: An asserted handshake SHALL be ignored when it coincides with rst; the reset value wins.
- REQ-032: Reset asserted mid-slot or mid-frame SHALL abort immediately. After release, the scan SHALL restart at digit 0, cnt 0, with held data zeroed.

Verification (SCAN_DIV=8, BLANK_CYC=2 unless noted)
- REQ-033: Reset release, then run 32 cycles. Required response:
  - ssd_ctl is 1111 for 2 cycles, then 1110 for 6 cycles;
  - the same pattern repeats with 1101, 1011, 0111;
  - frame_done pulses once at cycle 31;
  - while driving, ssd_seg=8'hC0 (digit "0" with dp off).
- REQ-034: Update handshake. Assert upd_valid with upd_digits=16'h12A8, upd_dp=4'b0010 early in a frame. Required response:
  - no load until the upd_ready cycle;
  - the next frame shows digit0 {g..a}=7'h00 with ssd_seg[7]=1, digit1 {g..a}=7'h08 with ssd_seg[7]=0, digit2 7'h24, digit3 7'h79.
- REQ-035: Leading-zero suppression. Load 16'h0070 with lz_en=1. Required response: digits 3 and 2 drive ssd_seg=8'hFF while their ssd_ctl bit is low; digit 1 shows 7'h78; digit 0 shows 7'h40. With lz_en=0, digits 3 and 2 show 7'h40.
- REQ-036: Reset mid-operation. Assert rst for 1 cycle during the digit-2 DRIVE phase after loading 16'hFFFF. Required response: the next cycle shows ssd_ctl=1111 and ssd_seg=FF, the scan resumes from digit 0, and all digits show "0".
- REQ-037: Boundary parameters. With BLANK_CYC=0, ssd_ctl SHALL never be 1111 after the first post-reset cycle. Holding upd_valid=1 continuously SHALL load exactly once per frame.
